// File: rtl/sudoku_pkg.sv
// Shared constants, FSM state type, LFSR taps and puzzle-bank contents for the
// sudoku puzzle loader.
package sudoku_pkg;

    localparam int unsigned CELLS    = 81;
    localparam int unsigned CELL_W   = 4;
    localparam int unsigned VIS_W    = 2;
    localparam int unsigned MAP_W    = 324;
    localparam int unsigned VISMAP_W = 162;
    localparam int unsigned LFSR_W   = 16;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: bits 0,2,3,5 feed bit 15
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_LOAD,
        ST_DONE
    } loader_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

    // Bank solutions are shifted Latin-square grids; index and level rotate the digits
    function automatic logic [MAP_W-1:0] rom_map(input int unsigned lvl, input int unsigned idx);
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            m[CELL_W*k +: CELL_W] =
                CELL_W'(((3 * (k / 9)) + (k / 27) + (k % 9) + idx + 4 * lvl) % 9 + 1);
        end
        return m;
    endfunction

    // Higher levels reveal a sparser subset of cells
    function automatic logic [VISMAP_W-1:0] rom_vis(input int unsigned lvl, input int unsigned idx);
        logic [VISMAP_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            v[VIS_W*k +: VIS_W] = (((k * 5 + idx * 3) % (lvl + 2)) == 0) ? VIS_W'(1) : VIS_W'(0);
        end
        return v;
    endfunction

endpackage

// File: rtl/puzzle_loader_if.sv
// Request/response bus between the game FSM (master) and the puzzle loader (slave).
interface puzzle_loader_if #(
    parameter int unsigned LVL_W = 1,
    parameter int unsigned IDX_W = 3
);
    import sudoku_pkg::*;

    logic                 req;
    logic [LVL_W-1:0]     level;
    logic                 busy;
    logic                 valid;
    logic [IDX_W-1:0]     map_index;
    logic [MAP_W-1:0]     selected_map;
    logic [VISMAP_W-1:0]  selected_visibility;

    modport master (
        output req, level,
        input  busy, valid, map_index, selected_map, selected_visibility
    );

    modport slave (
        input  req, level,
        output busy, valid, map_index, selected_map, selected_visibility
    );

endinterface

// File: rtl/puzzle_rom.sv
// Combinational puzzle bank: (level, index) -> solution map and visibility mask.
module puzzle_rom
    import sudoku_pkg::*;
#(
    parameter  int unsigned NUM_LEVELS     = 2,
    parameter  int unsigned MAPS_PER_LEVEL = 8,
    localparam int unsigned LVL_W          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned IDX_W          = $clog2(MAPS_PER_LEVEL)
) (
    input  logic [LVL_W-1:0]    level,
    input  logic [IDX_W-1:0]    index,
    output logic [MAP_W-1:0]    map,
    output logic [VISMAP_W-1:0] visibility
);

    localparam int unsigned DEPTH = 1 << (LVL_W + IDX_W);

    logic [MAP_W-1:0]    map_tab [DEPTH];
    logic [VISMAP_W-1:0] vis_tab [DEPTH];

    // Unused level codes alias the hardest level so every address is defined
    for (genvar l = 0; l < (1 << LVL_W); l++) begin : g_lvl
        localparam int unsigned CONTENT_LVL = (l < int'(NUM_LEVELS)) ? l : NUM_LEVELS - 1;
        for (genvar i = 0; i < MAPS_PER_LEVEL; i++) begin : g_idx
            assign map_tab[l * MAPS_PER_LEVEL + i] = rom_map(CONTENT_LVL, i);
            assign vis_tab[l * MAPS_PER_LEVEL + i] = rom_vis(CONTENT_LVL, i);
        end
    end

    assign map        = map_tab[{level, index}];
    assign visibility = vis_tab[{level, index}];

endmodule

// File: rtl/puzzle_loader.sv
// Puzzle-bank loader: on req, draws an LFSR map index for the latched level and
// registers the ROM entry. Optional feature macro: PUZZLE_NO_REPEAT_EN.
module puzzle_loader
    import sudoku_pkg::*;
#(
    parameter int unsigned NUM_LEVELS     = 2,
    parameter int unsigned MAPS_PER_LEVEL = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic            clk,
    input logic            reset,
    puzzle_loader_if.slave bus
);

    localparam int unsigned LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned IDX_W = $clog2(MAPS_PER_LEVEL);

    loader_state_t       state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    cand;
    logic                accept_c;
    logic [IDX_W-1:0]    pick_c;

    logic                valid_q;
    logic [IDX_W-1:0]    map_index_q;
    logic [MAP_W-1:0]    map_q;
    logic [VISMAP_W-1:0] vis_q;
    logic [MAP_W-1:0]    rom_map_w;
    logic [VISMAP_W-1:0] rom_vis_w;

    // Free-running index source, independent of FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_step(lfsr_q);
    end

    assign cand = lfsr_q[IDX_W-1:0];

`ifdef PUZZLE_NO_REPEAT_EN
    localparam int unsigned HIST_N = 1 << LVL_W;

    logic [IDX_W-1:0]  last_q [HIST_N];
    logic [HIST_N-1:0] hist_vld_q;
    logic [1:0]        attempt_q, attempt_d;
    logic [IDX_W-1:0]  last_sel;
    logic              repeat_c;
    logic              force_c;

    // Reject a repeat of the level's last map; the fourth draw forces last+1
    always_comb begin
        last_sel  = last_q[lvl_q];
        repeat_c  = hist_vld_q[lvl_q] && (cand == last_sel);
        force_c   = (attempt_q == 2'd3);
        accept_c  = force_c || !repeat_c;
        pick_c    = force_c ? (last_sel + IDX_W'(1)) : cand;
        attempt_d = ((state_q == ST_DRAW) && !accept_c) ? (attempt_q + 2'd1) : 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            attempt_q  <= 2'd0;
            hist_vld_q <= '0;
            for (int unsigned n = 0; n < HIST_N; n++) last_q[n] <= '0;
        end else begin
            attempt_q <= attempt_d;
            if (state_q == ST_LOAD) begin
                last_q[lvl_q]     <= idx_q;
                hist_vld_q[lvl_q] <= 1'b1;
            end
        end
    end
`else
    assign accept_c = 1'b1;
    assign pick_c   = cand;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    lvl_d   = (32'(bus.level) >= NUM_LEVELS) ? LVL_W'(NUM_LEVELS - 1) : bus.level;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (accept_c) begin
                    idx_d   = pick_c;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    puzzle_rom #(
        .NUM_LEVELS     (NUM_LEVELS),
        .MAPS_PER_LEVEL (MAPS_PER_LEVEL)
    ) u_rom (
        .level      (lvl_q),
        .index      (idx_q),
        .map        (rom_map_w),
        .visibility (rom_vis_w)
    );

    // Presented outputs hold until the next LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            map_index_q <= '0;
            map_q       <= '0;
            vis_q       <= '0;
        end else begin
            valid_q <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD) begin
                map_index_q <= idx_q;
                map_q       <= rom_map_w;
                vis_q       <= rom_vis_w;
            end
        end
    end

    assign bus.busy                = (state_q != ST_IDLE);
    assign bus.valid               = valid_q;
    assign bus.map_index           = map_index_q;
    assign bus.selected_map        = map_q;
    assign bus.selected_visibility = vis_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench for puzzle_loader: random requests against a sudoku-grid
// reference model and an LFSR model of the index draw.
module tb_puzzle_loader;
    import sudoku_pkg::*;

    localparam int unsigned NUM_LEVELS = 2;
    localparam int unsigned MAPS       = 8;
    localparam int unsigned LVL_W      = 1;
    localparam int unsigned IDX_W      = 3;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    puzzle_loader_if #(.LVL_W(LVL_W), .IDX_W(IDX_W)) bus ();

    puzzle_loader #(
        .NUM_LEVELS     (NUM_LEVELS),
        .MAPS_PER_LEVEL (MAPS),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reference LFSR, stepping once per clock from the seed
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= nxt(m_lfsr);
    end

    int last_idx [NUM_LEVELS];
    bit hist_ok  [NUM_LEVELS];

    function automatic logic [MAP_W-1:0] exp_map(input int l, input int i);
        logic [MAP_W-1:0] m;
        m = '0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                int d;
                d = ((r % 3) * 3 + r / 3 + c + i + 4 * l) % 9 + 1;
                m[(r * 9 + c) * 4 +: 4] = 4'(d);
            end
        end
        return m;
    endfunction

    function automatic logic [VISMAP_W-1:0] exp_vis(input int l, input int i);
        logic [VISMAP_W-1:0] v;
        v = '0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                if ((((r * 9 + c) * 5 + i * 3) % (l + 2)) == 0) v[(r * 9 + c) * 2 +: 2] = 2'b01;
            end
        end
        return v;
    endfunction

    function automatic int clamp_lvl(input logic [LVL_W-1:0] lv);
        return (int'(lv) >= int'(NUM_LEVELS)) ? int'(NUM_LEVELS) - 1 : int'(lv);
    endfunction

    task automatic clear_hist();
        for (int n = 0; n < int'(NUM_LEVELS); n++) begin
            last_idx[n] = 0;
            hist_ok[n]  = 1'b0;
        end
    endtask

    // Issue one request from a negedge, predict its outcome, observe busy/valid
    task automatic send_req(input logic [LVL_W-1:0] lv, input bit spam,
                            output int first_valid, output int nvalid, output int nbusy,
                            output int exp_idx, output int exp_lvl, output int exp_lat);
        logic [15:0] s;
        int          draws;
        int          cand;
        bit          done;
        exp_lvl = clamp_lvl(lv);
        s       = m_lfsr;
        draws   = 0;
        done    = 1'b0;
        exp_idx = 0;
        while (!done) begin
            s    = nxt(s);
            cand = int'(s[IDX_W-1:0]);
`ifdef PUZZLE_NO_REPEAT_EN
            if (draws == 3) begin
                exp_idx = (last_idx[exp_lvl] + 1) % int'(MAPS);
                done    = 1'b1;
            end else if (hist_ok[exp_lvl] && cand == last_idx[exp_lvl]) begin
                draws++;
            end else begin
                exp_idx = cand;
                done    = 1'b1;
            end
`else
            exp_idx = cand;
            done    = 1'b1;
`endif
        end
        exp_lat           = draws + 3;
        last_idx[exp_lvl] = exp_idx;
        hist_ok[exp_lvl]  = 1'b1;

        bus.req     = 1'b1;
        bus.level   = lv;
        first_valid = -1;
        nvalid      = 0;
        nbusy       = 0;
        for (int t = 1; t <= exp_lat + 4; t++) begin
            @(negedge clk);
            bus.req = spam && (t <= exp_lat);
            if (bus.busy === 1'b1) nbusy++;
            if (bus.valid === 1'b1) begin
                nvalid++;
                if (first_valid < 0) first_valid = t;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        total++; if (bus.map_index !== '0) begin bad++; $display("FAIL reset_index: got %0d want 0", bus.map_index); end
        total++; if (bus.selected_map !== '0) begin bad++; $display("FAIL reset_map: got %h want 0", bus.selected_map); end
        total++; if (bus.selected_visibility !== '0) begin bad++; $display("FAIL reset_vis: got %h want 0", bus.selected_visibility); end
        reset = 1'b1;
        clear_hist();
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int fv, nv, nb, ei, el, lat;
        send_req(LVL_W'(0), 1'b0, fv, nv, nb, ei, el, lat);
        total++; if (fv != lat) begin bad++; $display("FAIL single_latency: got %0d want %0d", fv, lat); end
        total++; if (nv != 1) begin bad++; $display("FAIL single_valid_count: got %0d want 1", nv); end
        total++; if (nb != lat) begin bad++; $display("FAIL single_busy_cycles: got %0d want %0d", nb, lat); end
        total++; if (int'(bus.map_index) != ei) begin bad++; $display("FAIL single_index: got %0d want %0d", bus.map_index, ei); end
        total++; if (bus.selected_map !== exp_map(el, ei)) begin bad++; $display("FAIL single_map: got %h want %h", bus.selected_map, exp_map(el, ei)); end
        total++; if (bus.selected_visibility !== exp_vis(el, ei)) begin bad++; $display("FAIL single_vis: got %h want %h", bus.selected_visibility, exp_vis(el, ei)); end
        repeat (5) @(negedge clk);
        total++; if (bus.selected_map !== exp_map(el, ei)) begin bad++; $display("FAIL single_hold: got %h want %h", bus.selected_map, exp_map(el, ei)); end
    endtask

    task automatic test_levels();
        int fv, nv, nb, ei, el, lat;
        logic [LVL_W-1:0] lv;
        for (int n = 0; n < 9; n++) begin
            lv = (n == 8) ? LVL_W'(3) : LVL_W'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_req(lv, 1'b0, fv, nv, nb, ei, el, lat);
            total++; if (fv != lat) begin bad++; $display("FAIL level_latency[%0d]: got %0d want %0d", n, fv, lat); end
            total++; if (int'(bus.map_index) != ei) begin bad++; $display("FAIL level_index[%0d]: got %0d want %0d", n, bus.map_index, ei); end
            total++; if (bus.selected_map !== exp_map(el, ei)) begin bad++; $display("FAIL level_map[%0d] lvl=%0d: got %h want %h", n, el, bus.selected_map, exp_map(el, ei)); end
            total++; if (bus.selected_visibility !== exp_vis(el, ei)) begin bad++; $display("FAIL level_vis[%0d] lvl=%0d: got %h want %h", n, el, bus.selected_visibility, exp_vis(el, ei)); end
        end
    endtask

    task automatic test_req_ignored();
        int fv, nv, nb, ei, el, lat;
        for (int n = 0; n < 3; n++) begin
            send_req(LVL_W'($urandom_range(0, 1)), 1'b1, fv, nv, nb, ei, el, lat);
            total++; if (nv != 1) begin bad++; $display("FAIL ignored_valid_count[%0d]: got %0d want 1", n, nv); end
            total++; if (nb != lat) begin bad++; $display("FAIL ignored_busy_cycles[%0d]: got %0d want %0d", n, nb, lat); end
            total++; if (int'(bus.map_index) != ei) begin bad++; $display("FAIL ignored_index[%0d]: got %0d want %0d", n, bus.map_index, ei); end
        end
    endtask

`ifdef PUZZLE_NO_REPEAT_EN
    task automatic test_no_repeat();
        int fv, nv, nb, ei, el, lat, prev;
        prev = -1;
        for (int n = 0; n < 200; n++) begin
            send_req(LVL_W'(0), 1'b0, fv, nv, nb, ei, el, lat);
            total++; if (int'(bus.map_index) == prev) begin bad++; $display("FAIL norepeat_equal[%0d]: got %0d twice", n, prev); end
            total++; if (int'(bus.map_index) != ei) begin bad++; $display("FAIL norepeat_index[%0d]: got %0d want %0d", n, bus.map_index, ei); end
            total++; if (fv != lat) begin bad++; $display("FAIL norepeat_latency[%0d]: got %0d want %0d", n, fv, lat); end
            prev = int'(bus.map_index);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] seen [0:20];
        int          nv;
        nv        = 0;
        bus.level = LVL_W'(0);
        bus.req   = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            seen[t] = m_lfsr;
            if (t == 16) bus.req = 1'b0;
            if (bus.valid === 1'b1) begin
                nv++;
`ifndef PUZZLE_NO_REPEAT_EN
                total++; if ((t % 4) != 3) begin bad++; $display("FAIL held_valid_pos: got cycle %0d want cycle mod 4 == 3", t); end
                if (t >= 3) begin
                    total++; if (bus.map_index !== seen[t-2][IDX_W-1:0]) begin bad++; $display("FAIL held_index@%0d: got %0d want %0d", t, bus.map_index, seen[t-2][IDX_W-1:0]); end
                    total++; if (bus.selected_map !== exp_map(0, int'(seen[t-2][IDX_W-1:0]))) begin bad++; $display("FAIL held_map@%0d: got %h", t, bus.selected_map); end
                end
`endif
            end
        end
        repeat (8) @(negedge clk);
`ifndef PUZZLE_NO_REPEAT_EN
        total++; if (nv != 4) begin bad++; $display("FAIL held_valid_count: got %0d want 4", nv); end
`else
        total++; if (nv < 1) begin bad++; $display("FAIL held_valid_count: got %0d want at least 1", nv); end
`endif
    endtask

    task automatic test_reset_mid_load();
        int          nv, fv, vn, nb, ei, el, lat;
        logic [15:0] s0;
        nv        = 0;
        bus.level = LVL_W'($urandom_range(0, 1));
        bus.req   = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) nv++;
        end
        total++; if (nv != 0) begin bad++; $display("FAIL abort_valid: got %0d strobes want 0", nv); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        total++; if (bus.map_index !== '0) begin bad++; $display("FAIL abort_index: got %0d want 0", bus.map_index); end
        total++; if (bus.selected_map !== '0) begin bad++; $display("FAIL abort_map: got %h want 0", bus.selected_map); end
        total++; if (bus.selected_visibility !== '0) begin bad++; $display("FAIL abort_vis: got %h want 0", bus.selected_visibility); end
        reset = 1'b1;
        clear_hist();
        s0 = nxt(SEED);
        send_req(LVL_W'(1), 1'b0, fv, vn, nb, ei, el, lat);
        total++; if (bus.map_index !== s0[IDX_W-1:0]) begin bad++; $display("FAIL restart_index: got %0d want %0d", bus.map_index, s0[IDX_W-1:0]); end
        total++; if (bus.selected_map !== exp_map(1, int'(s0[IDX_W-1:0]))) begin bad++; $display("FAIL restart_map: got %h want %h", bus.selected_map, exp_map(1, int'(s0[IDX_W-1:0]))); end
        total++; if (fv != lat) begin bad++; $display("FAIL restart_latency: got %0d want %0d", fv, lat); end
    endtask

    initial begin
        bus.req   = 1'b0;
        bus.level = '0;
        test_reset();
        test_single();
        test_levels();
        test_req_ignored();
`ifdef PUZZLE_NO_REPEAT_EN
        test_no_repeat();
`endif
        test_back_to_back();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
